// File: rtl/stereo_stream_sync.sv
// Stereo pixel pairing: per-camera skew FIFOs feed a lock/resync/flush FSM that issues
// coordinate-matched left/right pairs to the SAD engine when it is not busy.
module stereo_stream_sync #(
    parameter int unsigned HRES       = 640,
    parameter int unsigned VRES       = 360,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cam1_valid_in,
    input  logic [7:0]  cam1_pixel_in,
    input  logic [10:0] cam1_hcount_in,
    input  logic [9:0]  cam1_vcount_in,
    input  logic        cam2_valid_in,
    input  logic [7:0]  cam2_pixel_in,
    input  logic [10:0] cam2_hcount_in,
    input  logic [9:0]  cam2_vcount_in,
    input  logic        sad_busy_in,
    output logic        pair_valid_out,
    output logic [7:0]  left_pixel_out,
    output logic [7:0]  right_pixel_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        frame_start_out,
    output logic [7:0]  drop_count_out,
    output logic        overflow_out,
    output logic [1:0]  state_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 29;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stereo_stream_sync: FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (HRES < 1 || HRES > 2048 || VRES < 1 || VRES > 1024) begin : g_bad_res
        $error("stereo_stream_sync: HRES/VRES exceed the coordinate port widths");
    end

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        STREAM     = 2'd1,
        RESYNC     = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Entry layout {pixel, vcount, hcount}: the low 21 bits are the ordering key directly.
    logic [EW-1:0] mem1_q [FIFO_DEPTH];
    logic [EW-1:0] mem2_q [FIFO_DEPTH];
    logic [AW-1:0] wr1_q, wr1_d, rd1_q, rd1_d;
    logic [AW-1:0] wr2_q, wr2_d, rd2_q, rd2_d;
    logic [AW:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    logic [EW-1:0] head1, head2;
    logic [20:0]   key1, key2;
    logic          have1, have2, full1, full2;
    logic          pop1, pop2, push1, push2, ovf1, ovf2;
    logic          pair_pop, drop_inc;

    logic          pair_valid_q, frame_start_q, overflow_q;
    logic [7:0]    left_q, right_q, drop_q;
    logic [10:0]   h_q;
    logic [9:0]    v_q;

    assign head1 = mem1_q[rd1_q];
    assign head2 = mem2_q[rd2_q];
    assign key1  = head1[20:0];
    assign key2  = head2[20:0];
    assign have1 = (cnt1_q != '0);
    assign have2 = (cnt2_q != '0);
    assign full1 = (cnt1_q == FULL_CNT);
    assign full2 = (cnt2_q == FULL_CNT);

    always_comb begin
        state_d  = state_q;
        pop1     = 1'b0;
        pop2     = 1'b0;
        pair_pop = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                pop1 = have1 && (key1 != '0);
                pop2 = have2 && (key2 != '0);
                if (have1 && have2 && key1 == '0 && key2 == '0) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (have1 && have2) begin
                    if (key1 == key2) begin
                        if (!sad_busy_in) begin
                            pop1     = 1'b1;
                            pop2     = 1'b1;
                            pair_pop = 1'b1;
                        end
                    end else begin
                        state_d = RESYNC;
                    end
                end
            end
            RESYNC: begin
                if (have1 && have2) begin
                    if (key1 == key2) begin
                        state_d = STREAM;
                    end else if (key1 < key2) begin
                        pop1     = 1'b1;
                        drop_inc = 1'b1;
                    end else begin
                        pop2     = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            FLUSH:   state_d = WAIT_FRAME;
            default: state_d = WAIT_FRAME;
        endcase

        // A same-cycle pop frees the slot, so a full FIFO still accepts that push.
        push1 = cam1_valid_in && (!full1 || pop1) && (state_q != FLUSH);
        push2 = cam2_valid_in && (!full2 || pop2) && (state_q != FLUSH);
        ovf1  = cam1_valid_in && full1 && !pop1 && (state_q != FLUSH);
        ovf2  = cam2_valid_in && full2 && !pop2 && (state_q != FLUSH);
        if (ovf1 || ovf2) begin
            state_d = FLUSH;
        end

        if (state_q == FLUSH) begin
            wr1_d  = '0;
            rd1_d  = '0;
            cnt1_d = '0;
            wr2_d  = '0;
            rd2_d  = '0;
            cnt2_d = '0;
        end else begin
            wr1_d  = push1 ? wr1_q + 1'b1 : wr1_q;
            rd1_d  = pop1  ? rd1_q + 1'b1 : rd1_q;
            cnt1_d = cnt1_q + (AW + 1)'(push1) - (AW + 1)'(pop1);
            wr2_d  = push2 ? wr2_q + 1'b1 : wr2_q;
            rd2_d  = pop2  ? rd2_q + 1'b1 : rd2_q;
            cnt2_d = cnt2_q + (AW + 1)'(push2) - (AW + 1)'(pop2);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push1) mem1_q[wr1_q] <= {cam1_pixel_in, cam1_vcount_in, cam1_hcount_in};
        if (push2) mem2_q[wr2_q] <= {cam2_pixel_in, cam2_vcount_in, cam2_hcount_in};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= WAIT_FRAME;
            wr1_q   <= '0;
            rd1_q   <= '0;
            cnt1_q  <= '0;
            wr2_q   <= '0;
            rd2_q   <= '0;
            cnt2_q  <= '0;
        end else begin
            state_q <= state_d;
            wr1_q   <= wr1_d;
            rd1_q   <= rd1_d;
            cnt1_q  <= cnt1_d;
            wr2_q   <= wr2_d;
            rd2_q   <= rd2_d;
            cnt2_q  <= cnt2_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pair_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            left_q        <= '0;
            right_q       <= '0;
            h_q           <= '0;
            v_q           <= '0;
            drop_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            pair_valid_q  <= pair_pop;
            frame_start_q <= pair_pop && (key1 == '0);
            if (pair_pop) begin
                left_q  <= head1[28:21];
                right_q <= head2[28:21];
                h_q     <= head1[10:0];
                v_q     <= head1[20:11];
            end
            if (drop_inc && drop_q != '1) begin
                drop_q <= drop_q + 8'd1;
            end
            if (ovf1 || ovf2) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pair_valid_out  = pair_valid_q;
    assign frame_start_out = frame_start_q;
    assign left_pixel_out  = left_q;
    assign right_pixel_out = right_q;
    assign hcount_out      = h_q;
    assign vcount_out      = v_q;
    assign drop_count_out  = drop_q;
    assign overflow_out    = overflow_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_stereo_stream_sync.sv
// Directed bench for stereo_stream_sync: pairing, skew, stall, resync, overflow, relock and reset.
module tb_stereo_stream_sync;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        cam1_valid_in = 1'b0;
    logic [7:0]  cam1_pixel_in = '0;
    logic [10:0] cam1_hcount_in = '0;
    logic [9:0]  cam1_vcount_in = '0;
    logic        cam2_valid_in = 1'b0;
    logic [7:0]  cam2_pixel_in = '0;
    logic [10:0] cam2_hcount_in = '0;
    logic [9:0]  cam2_vcount_in = '0;
    logic        sad_busy_in = 1'b0;
    logic        pair_valid_out;
    logic [7:0]  left_pixel_out;
    logic [7:0]  right_pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        frame_start_out;
    logic [7:0]  drop_count_out;
    logic        overflow_out;
    logic [1:0]  state_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0]  l;
        logic [7:0]  r;
        logic [10:0] h;
        logic [9:0]  v;
        logic        fs;
    } pair_t;

    pair_t exp_q[$];

    stereo_stream_sync #(.HRES(640), .VRES(360), .FIFO_DEPTH(16)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cam1_valid_in   (cam1_valid_in),
        .cam1_pixel_in   (cam1_pixel_in),
        .cam1_hcount_in  (cam1_hcount_in),
        .cam1_vcount_in  (cam1_vcount_in),
        .cam2_valid_in   (cam2_valid_in),
        .cam2_pixel_in   (cam2_pixel_in),
        .cam2_hcount_in  (cam2_hcount_in),
        .cam2_vcount_in  (cam2_vcount_in),
        .sad_busy_in     (sad_busy_in),
        .pair_valid_out  (pair_valid_out),
        .left_pixel_out  (left_pixel_out),
        .right_pixel_out (right_pixel_out),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .frame_start_out (frame_start_out),
        .drop_count_out  (drop_count_out),
        .overflow_out    (overflow_out),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] lpix(input int h, input int v);
        return 8'(h * 7 + v * 13 + 1);
    endfunction

    function automatic logic [7:0] rpix(input int h, input int v);
        return 8'(h * 5 + v * 3 + 100);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pair(input int h, input int v);
        pair_t p;
        p.l  = lpix(h, v);
        p.r  = rpix(h, v);
        p.h  = 11'(h);
        p.v  = 10'(v);
        p.fs = (h == 0 && v == 0);
        exp_q.push_back(p);
    endtask

    // One clock: sample after the edge, score any pair and the stall rule.
    task automatic tick();
        pair_t e;
        pair_t o;
        @(posedge clk_in);
        #1;
        if (sad_busy_in) begin
            vectors++;
            assert (pair_valid_out === 1'b0) else begin
                miscompares++;
                $error("FAIL busy_hold: pair_valid_out=%0b expected 0", pair_valid_out);
            end
        end
        if (pair_valid_out === 1'b1) begin
            o = {left_pixel_out, right_pixel_out, hcount_out, vcount_out, frame_start_out};
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_pair: got h=%0d v=%0d, expected no pair", hcount_out, vcount_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                assert (o === e) else begin
                    miscompares++;
                    $error("FAIL pair_data: observed %0h expected %0h (h=%0d v=%0d)", o, e, e.h, e.v);
                end
            end
        end
    endtask

    task automatic drive(input logic v1, input int h1, input int y1,
                         input logic v2, input int h2, input int y2);
        cam1_valid_in  = v1;
        cam1_hcount_in = 11'(h1);
        cam1_vcount_in = 10'(y1);
        cam1_pixel_in  = lpix(h1, y1);
        cam2_valid_in  = v2;
        cam2_hcount_in = 11'(h2);
        cam2_vcount_in = 10'(y2);
        cam2_pixel_in  = rpix(h2, y2);
    endtask

    task automatic idle(input int n);
        cam1_valid_in = 1'b0;
        cam2_valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({pair_valid_out, left_pixel_out, right_pixel_out, hcount_out, vcount_out,
                    frame_start_out, drop_count_out, overflow_out, state_out});
    endfunction

    initial begin
        // Reset
        #2 rst_in = 1'b1;
        #1 chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Aligned streams (0,0)..(0,7): lock then pair in order
        for (int i = 0; i < 8; i++) expect_pair(i, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 0, 1'b1, i, 0);
            tick();
        end
        idle(6);
        chk("aligned_all_paired", 64'(exp_q.size()), 64'd0);
        chk("aligned_drop", 64'(drop_count_out), 64'd0);
        chk("aligned_state", 64'(state_out), 64'd1);

        // Unstalled latency: pushed at one edge, pair visible after the next
        drive(1'b1, 8, 0, 1'b1, 8, 0);
        tick();
        cam1_valid_in = 1'b0;
        cam2_valid_in = 1'b0;
        expect_pair(8, 0);
        tick();
        chk("latency_2cyc", 64'(exp_q.size()), 64'd0);

        // cam2 lags cam1 by 5 cycles on row 1
        for (int i = 0; i < 8; i++) expect_pair(i, 1);
        for (int c = 0; c < 13; c++) begin
            drive(c < 8, c, 1, c >= 5, c - 5, 1);
            tick();
        end
        idle(8);
        chk("skew_all_paired", 64'(exp_q.size()), 64'd0);
        chk("skew_overflow", 64'(overflow_out), 64'd0);

        // Frame wrap (359,639) -> (0,0)
        expect_pair(639, 359);
        expect_pair(0, 0);
        drive(1'b1, 639, 359, 1'b1, 639, 359);
        tick();
        drive(1'b1, 0, 0, 1'b1, 0, 0);
        tick();
        idle(4);
        chk("wrap_paired", 64'(exp_q.size()), 64'd0);
        chk("wrap_state", 64'(state_out), 64'd1);

        // SAD busy for 6 cycles while 4 pixels arrive
        sad_busy_in = 1'b1;
        for (int i = 1; i <= 4; i++) expect_pair(i, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 0, 1'b1, i, 0);
            tick();
        end
        idle(2);
        chk("busy_nothing_out", 64'(exp_q.size()), 64'd4);
        sad_busy_in = 1'b0;
        idle(4);
        chk("busy_release_burst", 64'(exp_q.size()), 64'd0);
        idle(1);

        // cam1 skips (0,6): one cam2 pixel dropped in RESYNC
        expect_pair(5, 0);
        expect_pair(7, 0);
        expect_pair(8, 0);
        drive(1'b1, 5, 0, 1'b1, 5, 0);
        tick();
        drive(1'b1, 7, 0, 1'b1, 6, 0);
        tick();
        drive(1'b1, 8, 0, 1'b1, 7, 0);
        tick();
        chk("resync_entered", 64'(state_out), 64'd2);
        drive(1'b0, 0, 0, 1'b1, 8, 0);
        tick();
        idle(6);
        chk("resync_paired", 64'(exp_q.size()), 64'd0);
        chk("resync_drop", 64'(drop_count_out), 64'd1);
        chk("resync_state", 64'(state_out), 64'd1);

        // Overflow: busy held while 17 pixels arrive
        sad_busy_in = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 9 + k, 0, 1'b1, 9 + k, 0);
            tick();
        end
        chk("ovf_flag", 64'(overflow_out), 64'd1);
        chk("ovf_flush_state", 64'(state_out), 64'd3);
        idle(1);
        chk("ovf_wait_state", 64'(state_out), 64'd0);
        sad_busy_in = 1'b0;
        idle(3);
        drive(1'b1, 26, 0, 1'b1, 26, 0);
        tick();
        idle(2);
        chk("ovf_no_stale_pair", 64'(exp_q.size()), 64'd0);
        chk("ovf_wait_no_drop", 64'(drop_count_out), 64'd1);
        expect_pair(0, 0);
        expect_pair(1, 0);
        drive(1'b1, 0, 0, 1'b1, 0, 0);
        tick();
        drive(1'b1, 1, 0, 1'b1, 1, 0);
        tick();
        idle(4);
        chk("ovf_relock", 64'(exp_q.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow_out), 64'd1);

        // Reset, then start mid-frame at (10,5): discarded until (0,0)
        rst_in = 1'b1;
        #1 chk("reset2_outputs", all_outs(), 64'd0);
        tick();
        rst_in = 1'b0;
        for (int i = 10; i < 13; i++) begin
            drive(1'b1, i, 5, 1'b1, i, 5);
            tick();
        end
        idle(2);
        chk("midframe_wait", 64'(state_out), 64'd0);
        expect_pair(0, 0);
        expect_pair(1, 0);
        drive(1'b1, 0, 0, 1'b1, 0, 0);
        tick();
        drive(1'b1, 1, 0, 1'b1, 1, 0);
        tick();
        idle(4);
        chk("midframe_lock", 64'(exp_q.size()), 64'd0);
        chk("midframe_drop", 64'(drop_count_out), 64'd0);
        chk("midframe_state", 64'(state_out), 64'd1);

        // Asynchronous reset while a pair is on the outputs
        expect_pair(2, 0);
        drive(1'b1, 2, 0, 1'b1, 2, 0);
        tick();
        cam1_valid_in = 1'b0;
        cam2_valid_in = 1'b0;
        tick();
        chk("async_pair_present", 64'(pair_valid_out), 64'd1);
        #2 rst_in = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        #10 rst_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
